// File: rtl/apb_soc_config.sv
// rtl/apb_soc_config.sv - APB runtime SoC configuration with shadowed commit handshake
module apb_soc_config #(
   parameter int          APB_ADDR_WIDTH = 32,
   parameter int          NUM_SCRATCH    = 4,
   parameter logic [31:0] BOOT_ADDR_RST  = 32'h8000,
   parameter int          INSTR_RAM_SIZE = 32768,
   parameter int          DATA_RAM_SIZE  = 32768,
   parameter bit          USE_ZERO_RISCY = 1'b0,
   parameter bit          RISCY_RV32F    = 1'b1,
   parameter bit          ZERO_RV32M     = 1'b0,
   parameter bit          ZERO_RV32E     = 1'b0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [APB_ADDR_WIDTH-1:0] PADDR,
   input  logic [31:0]               PWDATA,
   input  logic                      PWRITE,
   input  logic                      PSEL,
   input  logic                      PENABLE,
   output logic [31:0]               PRDATA,
   output logic                      PREADY,
   output logic                      PSLVERR,
   output logic [31:0]               boot_addr_o,
   output logic                      fetch_en_o,
   output logic                      fpu_en_o,
   output logic                      cfg_req_o,
   input  logic                      cfg_ack_i
);

   typedef enum logic [1:0] {IDLE, REQ, APPLY} state_t;

   localparam bit          FPU_OK  = RISCY_RV32F && !USE_ZERO_RISCY;
   localparam logic [31:0] FEATURE = {16'h0C5A, 4'h0, 4'(NUM_SCRATCH), 4'h0,
                                      ZERO_RV32E, ZERO_RV32M, RISCY_RV32F, USE_ZERO_RISCY};

   state_t state_q, state_d;
   logic [31:0] boot_sh_q;
   logic        fetch_sh_q, fpu_sh_q, lock_q, aborted_q;
   logic [31:0] scratch_q [NUM_SCRATCH];
   logic        rd_phase_q, rd_err_q;

   logic [5:0]             idx;
   logic                   wr_acc, rd_acc, rd_first, pending;
   logic [NUM_SCRATCH-1:0] scr_sel, scr_we;
   logic                   scr_hit;
   logic [31:0]            rd_data, rd_scr;
   logic                   rd_err, wr_err;
   logic                   boot_we, ctrl_we, lock_set, commit_go, abort_go, apply_go;
   logic                   unused_addr;

   assign idx         = PADDR[7:2];
   assign unused_addr = ^{PADDR[APB_ADDR_WIDTH-1:8], PADDR[1:0]};
   assign wr_acc      = PSEL && PENABLE && PWRITE;
   assign rd_acc      = PSEL && PENABLE && !PWRITE;
   assign rd_first    = rd_acc && !rd_phase_q;
   assign pending     = (state_q != IDLE);
   assign cfg_req_o   = (state_q == REQ);
   assign PREADY      = !rd_first;
   assign PSLVERR     = (wr_acc && wr_err) || (rd_acc && rd_phase_q && rd_err_q);

   always_comb begin
      scr_sel = '0;
      rd_scr  = '0;
      for (int i = 0; i < NUM_SCRATCH; i++) begin
         scr_sel[i] = (idx == 6'(6 + i));
         if (scr_sel[i]) rd_scr = scratch_q[i];
      end
      scr_hit = |scr_sel;
   end

   always_comb begin
      rd_data = '0;
      rd_err  = 1'b0;
      case (idx)
         6'd0: rd_data = FEATURE;
         6'd1: rd_data = 32'(INSTR_RAM_SIZE);
         6'd2: rd_data = 32'(DATA_RAM_SIZE);
         6'd3: rd_data = boot_sh_q;
         6'd4: rd_data = {lock_q, 28'd0, 1'b0, fpu_sh_q, fetch_sh_q};
         6'd5: rd_data = {29'd0, aborted_q, lock_q, pending};
         default: begin
            if (scr_hit) rd_data = rd_scr;
            else         rd_err  = 1'b1;
         end
      endcase
   end

   // Lock-only CTRL writes are tested before the abort pattern so locking during REQ never aborts.
   always_comb begin
      wr_err    = 1'b0;
      boot_we   = 1'b0;
      ctrl_we   = 1'b0;
      lock_set  = 1'b0;
      commit_go = 1'b0;
      abort_go  = 1'b0;
      scr_we    = '0;
      if (wr_acc) begin
         case (idx)
            6'd0, 6'd1, 6'd2, 6'd5: wr_err = 1'b1;
            6'd3: begin
               if (lock_q || pending) wr_err  = 1'b1;
               else                   boot_we = 1'b1;
            end
            6'd4: begin
               if (PWDATA[31] && PWDATA[2:0] == 3'b000) begin
                  lock_set = 1'b1;
               end else if (state_q == REQ && !PWDATA[2] && !PWDATA[0]) begin
                  abort_go = 1'b1;
                  lock_set = PWDATA[31];
               end else if (pending || lock_q) begin
                  wr_err = 1'b1;
               end else begin
                  ctrl_we   = 1'b1;
                  lock_set  = PWDATA[31];
                  commit_go = PWDATA[2];
               end
            end
            default: begin
               if (scr_hit) scr_we = scr_sel;
               else         wr_err = 1'b1;
            end
         endcase
      end
   end

   always_comb begin
      state_d  = state_q;
      apply_go = 1'b0;
      case (state_q)
         IDLE:  if (commit_go) state_d = REQ;
         REQ: begin
            if (abort_go) begin
               state_d = IDLE;
            end else if (cfg_ack_i) begin
               state_d  = APPLY;
               apply_go = 1'b1;
            end
         end
         APPLY: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         boot_sh_q   <= BOOT_ADDR_RST;
         fetch_sh_q  <= 1'b0;
         fpu_sh_q    <= 1'b0;
         lock_q      <= 1'b0;
         aborted_q   <= 1'b0;
         boot_addr_o <= BOOT_ADDR_RST;
         fetch_en_o  <= 1'b0;
         fpu_en_o    <= 1'b0;
         rd_phase_q  <= 1'b0;
         rd_err_q    <= 1'b0;
         PRDATA      <= '0;
         for (int i = 0; i < NUM_SCRATCH; i++) scratch_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         rd_phase_q <= rd_first;
         if (boot_we) boot_sh_q <= PWDATA;
         if (ctrl_we) begin
            fetch_sh_q <= PWDATA[0];
            fpu_sh_q   <= PWDATA[1];
         end
         if (lock_set) lock_q <= 1'b1;
         if (abort_go) aborted_q <= 1'b1;
         // Shadows reach the core on the ack edge, so outputs move together with cfg_req_o falling.
         if (apply_go) begin
            boot_addr_o <= boot_sh_q;
            fetch_en_o  <= fetch_sh_q;
            fpu_en_o    <= fpu_sh_q && FPU_OK;
            aborted_q   <= 1'b0;
         end
         for (int i = 0; i < NUM_SCRATCH; i++)
            if (scr_we[i]) scratch_q[i] <= PWDATA;
         if (!PSEL) begin
            PRDATA <= '0;
         end else if (rd_first) begin
            PRDATA   <= rd_data;
            rd_err_q <= rd_err;
         end
      end
   end

endmodule

// File: tb/tb_apb_soc_config.sv
// tb/tb_apb_soc_config.sv - directed self-checking bench for apb_soc_config
module tb_apb_soc_config;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] PADDR, PWDATA, PRDATA;
   logic        PWRITE, PSEL, PENABLE, PREADY, PSLVERR;
   logic [31:0] boot_addr_o;
   logic        fetch_en_o, fpu_en_o, cfg_req_o, cfg_ack_i;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] rd;
   logic        err;
   int          waits;

   apb_soc_config dut (
      .clk(clk), .rst(rst),
      .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
      .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .boot_addr_o(boot_addr_o), .fetch_en_o(fetch_en_o), .fpu_en_o(fpu_en_o),
      .cfg_req_o(cfg_req_o), .cfg_ack_i(cfg_ack_i)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apb_write(input logic [31:0] a, input logic [31:0] d, output logic e);
      PADDR = a; PWDATA = d; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
      step();
      PENABLE = 1'b1;
      @(negedge clk);
      check("wr_pready", PREADY, 1);
      e = PSLVERR;
      step();
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
   endtask

   task automatic apb_read(input logic [31:0] a, output logic [31:0] d, output logic e,
                           output int w);
      PADDR = a; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
      step();
      PENABLE = 1'b1;
      w = 0;
      @(negedge clk);
      while (!PREADY && w < 4) begin
         w++;
         step();
         @(negedge clk);
      end
      check("rd_pready", PREADY, 1);
      d = PRDATA;
      e = PSLVERR;
      step();
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; PADDR = '0; PWDATA = '0; PWRITE = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
      cfg_ack_i = 1'b0;
      repeat (3) step();
      rst = 1'b0;
      @(negedge clk);
      check("rst_prdata", PRDATA, 0);
      check("rst_pready", PREADY, 1);
      check("rst_pslverr", PSLVERR, 0);
      check("rst_boot", boot_addr_o, 32'h8000);
      check("rst_fetch", fetch_en_o, 0);
      check("rst_req", cfg_req_o, 0);
      step();

      // feature and reset shadow
      apb_read(32'h00, rd, err, waits);
      check("feature", rd, 32'h0C5A0402);
      check("rd_waits", waits, 1);
      check("feature_err", err, 0);
      apb_read(32'h0C, rd, err, waits);
      check("boot_shadow_rst", rd, 32'h00008000);

      // commit with ack after 3 low cycles
      apb_write(32'h0C, 32'h100, err);
      check("boot_wr_err", err, 0);
      apb_write(32'h10, 32'h5, err);
      check("ctrl_wr_err", err, 0);
      for (int i = 0; i < 4; i++) begin
         cfg_ack_i = (i == 3);
         @(negedge clk);
         check($sformatf("req_c%0d", i + 1), cfg_req_o, 1);
         check($sformatf("boot_hold_c%0d", i + 1), boot_addr_o, 32'h8000);
         step();
      end
      cfg_ack_i = 1'b0;
      @(negedge clk);
      check("req_fall", cfg_req_o, 0);
      check("boot_applied", boot_addr_o, 32'h100);
      check("fetch_applied", fetch_en_o, 1);
      check("fpu_off", fpu_en_o, 0);
      step();
      apb_read(32'h14, rd, err, waits);
      check("status_after_commit", rd, 0);

      // abort by CTRL=0 in REQ, then a clean second commit
      apb_write(32'h0C, 32'h300, err);
      apb_write(32'h10, 32'h5, err);
      apb_write(32'h10, 32'h0, err);
      check("abort_err", err, 0);
      @(negedge clk);
      check("abort_req", cfg_req_o, 0);
      check("abort_boot", boot_addr_o, 32'h100);
      check("abort_fetch", fetch_en_o, 1);
      step();
      apb_read(32'h14, rd, err, waits);
      check("status_aborted", rd, 32'h4);
      apb_read(32'h10, rd, err, waits);
      check("ctrl_after_abort", rd, 32'h1);
      apb_read(32'h0C, rd, err, waits);
      check("boot_sh_after_abort", rd, 32'h300);
      apb_write(32'h10, 32'h7, err);
      check("commit2_err", err, 0);
      cfg_ack_i = 1'b1;
      @(negedge clk);
      check("commit2_req", cfg_req_o, 1);
      step();
      cfg_ack_i = 1'b0;
      @(negedge clk);
      check("commit2_req_fall", cfg_req_o, 0);
      check("commit2_boot", boot_addr_o, 32'h300);
      check("commit2_fpu", fpu_en_o, 1);
      step();
      apb_read(32'h14, rd, err, waits);
      check("status_cleared", rd, 0);

      // errors: unmapped read, read-only write, double commit
      apb_read(32'h3C, rd, err, waits);
      check("unmapped_err", err, 1);
      check("unmapped_data", rd, 0);
      apb_write(32'h00, 32'hFFFFFFFF, err);
      check("ro_wr_err", err, 1);
      apb_read(32'h00, rd, err, waits);
      check("feature_kept", rd, 32'h0C5A0402);
      apb_write(32'h10, 32'h5, err);
      check("commit3_err", err, 0);
      apb_read(32'h14, rd, err, waits);
      check("status_pending", rd, 32'h1);
      apb_write(32'h10, 32'h5, err);
      check("double_commit_err", err, 1);
      cfg_ack_i = 1'b1;
      step();
      cfg_ack_i = 1'b0;
      step();
      apb_read(32'h14, rd, err, waits);
      check("status_idle", rd, 0);

      // lock
      apb_write(32'h10, 32'h80000000, err);
      check("lock_err", err, 0);
      apb_write(32'h0C, 32'h200, err);
      check("locked_boot_err", err, 1);
      apb_read(32'h0C, rd, err, waits);
      check("locked_boot_kept", rd, 32'h300);
      apb_write(32'h10, 32'h6, err);
      check("locked_ctrl_err", err, 1);
      apb_write(32'h24, 32'hDEADBEEF, err);
      check("scratch_err", err, 0);
      apb_read(32'h24, rd, err, waits);
      check("scratch_rd", rd, 32'hDEADBEEF);
      apb_read(32'h14, rd, err, waits);
      check("status_locked", rd, 32'h2);
      apb_read(32'h10, rd, err, waits);
      check("ctrl_locked", rd, 32'h80000001);

      // reset clears lock; lock in REQ keeps commit; rst mid-commit
      rst = 1'b1;
      step();
      rst = 1'b0;
      apb_read(32'h14, rd, err, waits);
      check("status_after_rst", rd, 0);
      apb_write(32'h10, 32'h5, err);
      check("commit4_err", err, 0);
      apb_write(32'h10, 32'h80000000, err);
      check("lock_in_req_err", err, 0);
      @(negedge clk);
      check("lock_in_req_req", cfg_req_o, 1);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      check("rst2_req", cfg_req_o, 0);
      check("rst2_boot", boot_addr_o, 32'h8000);
      check("rst2_fetch", fetch_en_o, 0);
      check("rst2_fpu", fpu_en_o, 0);
      check("rst2_pready", PREADY, 1);
      check("rst2_prdata", PRDATA, 0);
      step();
      apb_read(32'h14, rd, err, waits);
      check("rst2_status", rd, 0);
      apb_read(32'h0C, rd, err, waits);
      check("rst2_boot_sh", rd, 32'h8000);
      apb_read(32'h24, rd, err, waits);
      check("rst2_scratch", rd, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
